delay_line: RTL and testbench
=============================

// Module: delay_line
// PURPOSE
//  Parametrised successor of the 1-bit fixed delay: delays a WIDTH-bit data word plus its valid flag
//  by a run-time selectable number of enabled cycles (1..MAX_DELAY), with a clock-enable stall.
//  Aligns side-band data with multi-cycle datapaths (e.g. the bitnet MAC/accumulate pipes)
//  whose latency changes with configuration.
// PARAMETERS
//  WIDTH          8   data bits carried alongside valid
//  MAX_DELAY      16  number of storage stages; maximum selectable delay (>=1)
//  DEFAULT_DELAY  1   delay in force after reset (1..MAX_DELAY)
//  DW             $clog2(MAX_DELAY+1)  width of delay_in (localparam, not overridable)
// PORTS
//  clk_in        in   1      clock; all logic on posedge
//  rst_in        in   1      synchronous, active-high reset
//  en_in         in   1      advance pipeline this cycle; low = full freeze
//  delay_in      in   DW     requested delay in enabled cycles
//  valid_in      in   1      input sample valid
//  data_in       in   WIDTH  input sample
//  valid_out     out  1      delayed valid
//  data_out      out  WIDTH  delayed data; forced 0 when valid_out=0
//  settled_out   out  1      1 = in RUN; delay stable for >= delay_q enabled cycles
// BEHAVIOUR
//  - Reset: all stage valid/data bits 0, delay_q=DEFAULT_DELAY, state RUN; valid_out=0, data_out=0,
//    settled_out=1.
//  - delay_c = clamp(delay_in): 0 -> 1, >MAX_DELAY -> MAX_DELAY.
//  - Storage: MAX_DELAY-stage shift of {valid,data}. On en_in=1: stage0<={valid_in,data_in},
//    stage[i]<=stage[i-1]. Output taps stage[delay_q-1] (registered path, no comb. in->out).
//  - Latency: sample accepted on enabled cycle t appears on outputs after exactly delay_q further
//    enabled cycles; en_in=0 cycles are not counted and hold all state and outputs.
//  - FSM {RUN, FLUSH}, flush counter fcnt[DW-1:0]:
//    RUN, en_in=1, delay_c!=delay_q: clear valid of every stage except the new stage0 write,
//      delay_q<=delay_c, fcnt<=delay_c-1, -> FLUSH.
//    FLUSH, en_in=1: if delay_c!=delay_q restart (same actions as above); elif fcnt==0 -> RUN;
//      else fcnt--.
//    en_in=0: no transition, delay_in ignored.
//  - settled_out = (state==RUN). Samples are accepted in FLUSH; they exit with the new delay.
//  - Simultaneous delay change + valid_in: the new sample is kept valid; only older samples drop.
//  - No stale sample ever emerges after a delay change (old-delay data is discarded, not retimed).
//  - Reset mid-FLUSH: back to RUN, DEFAULT_DELAY, pipeline empty.
// CONFIGURATION
//  DELAY_LINE_OCCUPANCY_EN defined: extra port occupancy_out (out, DW) = number of valid samples in
//    stages [0..delay_q-1]; updated registered with the shift; reset 0; cleared with the flush.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  delay_line_pkg: state_t enum {RUN, FLUSH}; function clamp_delay(delay, max) -> delay in 1..max.
//  Sub-module delay_line_flush_ctrl: FSM + fcnt + delay_q register, outputs flush pulse, delay_q,
//  settled; datapath (shift stages, tap mux, data gating) stays in delay_line.
// TESTING
//  1 Reset, delay_in=3, en=1: detect change -> FLUSH; valid_in pulse 0xA5 at cycle 0
//    -> valid_out/data_out=0xA5 exactly 3 cycles later; settled_out back 1 after 3 cycles.
//  2 delay=4 settled, 0x11 in, en_in low 2 cycles after accept -> output 6 clocks after accept.
//  3 Stream 0x01..0x08 at delay=5, switch to delay=2 mid-stream -> no old sample emerges; samples
//    accepted from the switch cycle onward appear 2 enabled cycles later; settled_out=0 for 2 cycles.
//  4 delay_in=0 -> behaves as 1; delay_in=MAX_DELAY+3 -> behaves as MAX_DELAY (16).
//  5 rst_in asserted during FLUSH with samples in flight -> next cycle valid_out=0, data_out=0,
//    settled_out=1, delay_q=DEFAULT_DELAY.
//  6 DELAY_LINE_OCCUPANCY_EN: 3 valid samples at delay=8 -> occupancy_out 1,2,3, then 0 after a
//    delay change.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the delay_line block.
package delay_line_pkg;

  // Flush controller states: RUN = delay stable, FLUSH = draining after a delay change.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Clamp a requested delay into the legal range 1..max_delay.
  function automatic int unsigned clamp_delay(input int unsigned delay,
                                              input int unsigned max_delay);
    int unsigned res;
    res = delay;
    if (delay == 0) begin
      res = 1;
    end else if (delay > max_delay) begin
      res = max_delay;
    end
    return res;
  endfunction

endpackage

// File: rtl/delay_line_flush_ctrl.sv
// Delay-change controller for delay_line: holds the active delay, detects
// changes and times the flush window (settled goes high once the new delay
// has been in force for delay_q enabled cycles).
module delay_line_flush_ctrl
  import delay_line_pkg::*;
#(
  parameter int unsigned DW            = 5,
  parameter int unsigned DEFAULT_DELAY = 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          en_in,
  input  logic [DW-1:0] delay_c,
  output logic          flush_c,
  output logic [DW-1:0] delay_q,
  output logic          settled
);

  state_t        state, state_nxt;
  logic [DW-1:0] fcnt, fcnt_nxt;
  logic [DW-1:0] delay_nxt;

  // State, flush counter, active delay and settled flag registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= RUN;
      fcnt    <= '0;
      delay_q <= DW'(DEFAULT_DELAY);
      settled <= 1'b1;
    end else begin
      state   <= state_nxt;
      fcnt    <= fcnt_nxt;
      delay_q <= delay_nxt;
      settled <= (state_nxt == RUN);
    end
  end

  // Next-state logic; a delay change (re)starts the flush from either state.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    delay_nxt = delay_q;
    flush_c   = 1'b0;
    if (en_in) begin
      if (delay_c != delay_q) begin
        flush_c   = 1'b1;
        delay_nxt = delay_c;
        fcnt_nxt  = delay_c - DW'(1);
        state_nxt = FLUSH;
      end else if (state == FLUSH) begin
        if (fcnt == '0) begin
          state_nxt = RUN;
        end else begin
          fcnt_nxt = fcnt - DW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/delay_line.sv
// Run-time selectable delay line for a WIDTH-bit word plus valid flag.
// Delay is 1..MAX_DELAY enabled cycles; en_in=0 freezes everything.
// Optional feature: define DELAY_LINE_OCCUPANCY_EN to add occupancy_out,
// the number of valid samples inside the active delay window.
module delay_line
  import delay_line_pkg::*;
#(
  parameter int unsigned  WIDTH         = 8,
  parameter int unsigned  MAX_DELAY     = 16,
  parameter int unsigned  DEFAULT_DELAY = 1,
  localparam int unsigned DW            = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic [DW-1:0]    delay_in,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
`ifdef DELAY_LINE_OCCUPANCY_EN
  output logic [DW-1:0]    occupancy_out,
`endif
  output logic             settled_out
);

  logic [DW-1:0]        delay_c;
  logic [DW-1:0]        delay_q;
  logic                 flush_c;
  logic [MAX_DELAY-1:0] st_v;
  logic [MAX_DELAY-1:0] nxt_v;
  logic [WIDTH-1:0]     st_d [MAX_DELAY];

  // Requested delay forced into the legal range.
  always_comb begin
    delay_c = DW'(clamp_delay(32'(delay_in), MAX_DELAY));
  end

  delay_line_flush_ctrl #(
    .DW            (DW),
    .DEFAULT_DELAY (DEFAULT_DELAY)
  ) u_flush_ctrl (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .en_in   (en_in),
    .delay_c (delay_c),
    .flush_c (flush_c),
    .delay_q (delay_q),
    .settled (settled_out)
  );

  // Next valid vector: on a flush only the incoming sample survives.
  always_comb begin
    nxt_v    = '0;
    nxt_v[0] = valid_in;
    for (int i = 1; i < MAX_DELAY; i++) begin
      nxt_v[i] = flush_c ? 1'b0 : st_v[i-1];
    end
  end

  // Storage shift register; data bits shift unconditionally, valid follows nxt_v.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st_v <= '0;
      for (int i = 0; i < MAX_DELAY; i++) begin
        st_d[i] <= '0;
      end
    end else if (en_in) begin
      st_v    <= nxt_v;
      st_d[0] <= data_in;
      for (int i = 1; i < MAX_DELAY; i++) begin
        st_d[i] <= st_d[i-1];
      end
    end
  end

  // Output tap at stage delay_q-1; data gated to zero when not valid.
  always_comb begin
    valid_out = 1'b0;
    data_out  = '0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (delay_q == DW'(i + 1)) begin
        valid_out = st_v[i];
        data_out  = st_v[i] ? st_d[i] : '0;
      end
    end
  end

`ifdef DELAY_LINE_OCCUPANCY_EN
  logic [DW-1:0] delay_nxt;
  logic [DW-1:0] occ_nxt;

  // Count valid samples that will sit inside the active window after this edge.
  always_comb begin
    delay_nxt = flush_c ? delay_c : delay_q;
    occ_nxt   = '0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if ((DW'(i) < delay_nxt) && nxt_v[i]) begin
        occ_nxt = occ_nxt + DW'(1);
      end
    end
  end

  // Occupancy register, advanced together with the shift.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      occupancy_out <= '0;
    end else if (en_in) begin
      occupancy_out <= occ_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_delay_line.sv
// Directed self-checking bench for delay_line (WIDTH=8, MAX_DELAY=16, DEFAULT_DELAY=1).
module tb_delay_line;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_DELAY = 16;
  localparam int unsigned DW        = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DW-1:0]    delay;
  logic             vin;
  logic [WIDTH-1:0] din;
  logic             vout;
  logic [WIDTH-1:0] dout;
  logic             settled;
`ifdef DELAY_LINE_OCCUPANCY_EN
  logic [DW-1:0]    occ;
`endif

  int tests = 0;
  int fails = 0;

  delay_line #(
    .WIDTH         (WIDTH),
    .MAX_DELAY     (MAX_DELAY),
    .DEFAULT_DELAY (1)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .en_in         (en),
    .delay_in      (delay),
    .valid_in      (vin),
    .data_in       (din),
    .valid_out     (vout),
    .data_out      (dout),
`ifdef DELAY_LINE_OCCUPANCY_EN
    .occupancy_out (occ),
`endif
    .settled_out   (settled)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [7:0] ed, input logic es);
    check({tag, ".valid"}, 32'(vout), 32'(ev));
    check({tag, ".data"}, 32'(dout), 32'(ed));
    check({tag, ".settled"}, 32'(settled), 32'(es));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; delay = DW'(1); vin = 1'b0; din = '0;
    tick(); tick();
    check_out("reset", 1'b0, 8'h00, 1'b1);
`ifdef DELAY_LINE_OCCUPANCY_EN
    check("reset.occ", 32'(occ), 32'd0);
`endif
    rst = 1'b0;

    // 1: change to delay 3 with a sample on the change cycle.
    en = 1'b1; delay = DW'(3); vin = 1'b1; din = 8'hA5;
    for (int k = 1; k <= 4; k++) begin
      tick();
      vin = 1'b0; din = 8'h00;
      check_out($sformatf("t1.k%0d", k), k == 3, (k == 3) ? 8'hA5 : 8'h00, k == 4);
    end

    // 2: delay 4, two stalled cycles after accept.
    delay = DW'(4);
    for (int k = 0; k < 6; k++) tick();
    check("t2.settled", 32'(settled), 32'd1);
    vin = 1'b1; din = 8'h11;
    tick();
    vin = 1'b0; din = 8'h00;
    check_out("t2.c1", 1'b0, 8'h00, 1'b1);
    en = 1'b0;
    tick(); check_out("t2.c2", 1'b0, 8'h00, 1'b1);
    tick(); check_out("t2.c3", 1'b0, 8'h00, 1'b1);
    en = 1'b1;
    tick(); check_out("t2.c4", 1'b0, 8'h00, 1'b1);
    tick(); check_out("t2.c5", 1'b0, 8'h00, 1'b1);
    tick(); check_out("t2.c6", 1'b1, 8'h11, 1'b1);
    en = 1'b0;
    tick(); check_out("t2.hold", 1'b1, 8'h11, 1'b1);
    en = 1'b1;
    tick(); check_out("t2.after", 1'b0, 8'h00, 1'b1);

    // 3: stream at delay 5, switch to delay 2 on the fourth sample.
    delay = DW'(5);
    for (int k = 0; k < 7; k++) tick();
    for (int k = 1; k <= 10; k++) begin
      delay = (k >= 4) ? DW'(2) : DW'(5);
      vin   = (k <= 8);
      din   = (k <= 8) ? 8'(k) : 8'h00;
      tick();
      check_out($sformatf("t3.k%0d", k), (k >= 5) && (k <= 9),
                ((k >= 5) && (k <= 9)) ? 8'(k - 1) : 8'h00, !((k == 4) || (k == 5)));
    end

    // 4a: delay_in=0 acts as delay 1.
    delay = DW'(0); vin = 1'b1; din = 8'h3C;
    tick();
    vin = 1'b0; din = 8'h00;
    check_out("t4.zero", 1'b1, 8'h3C, 1'b0);
    tick();
    check_out("t4.zero2", 1'b0, 8'h00, 1'b1);

    // 4b: delay_in above MAX_DELAY acts as 16.
    delay = DW'(MAX_DELAY + 3); vin = 1'b1; din = 8'h5A;
    for (int k = 1; k <= 17; k++) begin
      tick();
      vin = 1'b0; din = 8'h00;
      check_out($sformatf("t4.max.k%0d", k), k == 16, (k == 16) ? 8'h5A : 8'h00, k == 17);
    end

    // 5: reset while flushing with samples in flight.
    delay = DW'(6); vin = 1'b1; din = 8'h77;
    tick();
    din = 8'h78;
    tick();
    vin = 1'b0; din = 8'h00;
    tick();
    rst = 1'b1;
    tick();
    check_out("t5.rst", 1'b0, 8'h00, 1'b1);
`ifdef DELAY_LINE_OCCUPANCY_EN
    check("t5.occ", 32'(occ), 32'd0);
`endif
    rst = 1'b0; delay = DW'(1); vin = 1'b1; din = 8'h99;
    tick();
    vin = 1'b0; din = 8'h00;
    check_out("t5.default", 1'b1, 8'h99, 1'b1);
    tick();
    check_out("t5.empty", 1'b0, 8'h00, 1'b1);

`ifdef DELAY_LINE_OCCUPANCY_EN
    // 6: occupancy counts samples in the window, cleared by a delay change.
    delay = DW'(8);
    for (int k = 0; k < 10; k++) tick();
    check("t6.idle", 32'(occ), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      vin = 1'b1; din = 8'(8'h40 + k);
      tick();
      check($sformatf("t6.occ%0d", k), 32'(occ), 32'(k));
    end
    vin = 1'b0; din = 8'h00;
    tick();
    check("t6.keep", 32'(occ), 32'd3);
    delay = DW'(3);
    tick();
    check("t6.flush", 32'(occ), 32'd0);
    check("t6.settled", 32'(settled), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
